// File: rtl/writeback_unit.sv
// Writeback queue: merges ALU and load results into a FIFO that drains into the register file.
// Optional WB_BYPASS_EN adds fwd_valid/fwd_data, forwarding the newest queued value for chk_reg.
module writeback_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,

    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,

    input  logic        wb_hold,
    output logic        write_en,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,

    input  logic [4:0]  chk_reg,
    output logic        chk_pending
`ifdef WB_BYPASS_EN
    ,
    output logic        fwd_valid,
    output logic [31:0] fwd_data
`endif
);

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [4:0]  ent_reg_q  [DEPTH];
    logic [31:0] ent_data_q [DEPTH];

    logic        full;
    logic        empty;
    logic        mem_fire;
    logic        alu_fire;
    logic        push_en;
    logic        pop_en;
    logic [4:0]  push_reg;
    logic [31:0] push_data;
    logic        chk_hit;
    logic [PtrW-1:0] scan_idx;
`ifdef WB_BYPASS_EN
    logic [31:0] fwd_match;
`endif

    // Handshake and push selection; reset forces the interface to its idle view.
    always_comb begin
        full      = (count_q == FullCount);
        empty     = (count_q == '0);
        mem_ready = !rst_n || !full;
        alu_ready = (!rst_n || !full) && !mem_valid;
        mem_fire  = mem_valid && mem_ready;
        alu_fire  = alu_valid && alu_ready;
        push_reg  = mem_fire ? mem_reg  : alu_reg;
        push_data = mem_fire ? mem_data : alu_data;
        // Writes to x0 complete the handshake but never occupy an entry.
        push_en   = rst_n && ((mem_fire && (mem_reg != 5'd0)) ||
                              (alu_fire && (alu_reg != 5'd0)));
    end

    always_comb begin
        write_en   = rst_n && !empty && !wb_hold;
        pop_en     = write_en;
        write_reg  = '0;
        write_data = '0;
        if (rst_n && !empty) begin
            write_reg  = ent_reg_q[rd_ptr_q];
            write_data = ent_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_en);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_en);
        count_d  = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ent_reg_q[wr_ptr_q]  <= push_reg;
            ent_data_q[wr_ptr_q] <= push_data;
        end
    end

    // Scan oldest to newest so the last match is the newest queued value.
    always_comb begin
        chk_hit  = 1'b0;
        scan_idx = '0;
`ifdef WB_BYPASS_EN
        fwd_match = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PtrW'(k);
            if ((CntW'(k) < count_q) && (ent_reg_q[scan_idx] == chk_reg)) begin
                chk_hit = 1'b1;
`ifdef WB_BYPASS_EN
                fwd_match = ent_data_q[scan_idx];
`endif
            end
        end
        chk_pending = rst_n && (chk_reg != 5'd0) && chk_hit;
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        fwd_valid = chk_pending;
        fwd_data  = chk_pending ? fwd_match : 32'd0;
    end
`endif

endmodule
